// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-requester ALU arbiter: ALU op encodings,
// arbiter FSM states and requester count.
package alu_arbiter_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_control_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } arb_state_t;

    localparam int ARB_N_REQ = 2;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by the arbiter; unknown op encodings yield a zero
// result with no overflow.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0]  i_a,
    input  logic [N-1:0]  i_b,
    input  alu_control_t  i_control,
    output logic [N-1:0]  o_result,
    output logic          o_overflow,
    output logic          o_zero,
    output logic          o_equal
);

    logic [N-1:0] w_sum;
    logic [N-1:0] w_diff;
    logic         w_slt;

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;
    assign w_slt  = $signed(i_a) < $signed(i_b);

    // Operation select; overflow is only meaningful for signed add/sub
    always_comb begin
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_control)
            ALU_AND: o_result = i_a & i_b;
            ALU_OR:  o_result = i_a | i_b;
            ALU_XOR: o_result = i_a ^ i_b;
            ALU_NOR: o_result = ~(i_a | i_b);
            ALU_ADD: begin
                o_result   = w_sum;
                o_overflow = (i_a[N-1] == i_b[N-1]) && (w_sum[N-1] != i_a[N-1]);
            end
            ALU_SUB: begin
                o_result   = w_diff;
                o_overflow = (i_a[N-1] != i_b[N-1]) && (w_diff[N-1] != i_a[N-1]);
            end
            ALU_SLT: o_result = {{(N-1){1'b0}}, w_slt};
            default: o_result = '0;
        endcase
    end

    assign o_zero  = (o_result == '0);
    assign o_equal = (i_a == i_b);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two valid/ready requesters;
// one registered, id-tagged response per accepted request.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic [N-1:0]  r0_a,
    input  logic [N-1:0]  r0_b,
    input  alu_control_t  r0_control,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic [N-1:0]  r1_a,
    input  logic [N-1:0]  r1_b,
    input  alu_control_t  r1_control,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_id,
    output logic [N-1:0]  rsp_result,
    output logic          rsp_overflow,
    output logic          rsp_zero,
    output logic          rsp_equal
);

    arb_state_t           r_state;
    arb_state_t           w_next_state;
    logic                 r_prio;
    logic [N-1:0]         r_op_a;
    logic [N-1:0]         r_op_b;
    alu_control_t         r_op_ctrl;
    logic                 r_op_id;
    logic [ARB_N_REQ-1:0] w_req_valid;
    logic                 w_grant_id;
    logic                 w_handshake;
    logic [N-1:0]         w_alu_result;
    logic                 w_alu_overflow;
    logic                 w_alu_zero;
    logic                 w_alu_equal;

    assign w_req_valid = {r1_valid, r0_valid};

    // Grant selection: prio only breaks ties when both requesters are valid
    always_comb begin
        w_grant_id = 1'b0;
        if (w_req_valid == 2'b11) begin
            w_grant_id = r_prio;
        end else if (w_req_valid == 2'b10) begin
            w_grant_id = 1'b1;
        end else begin
            w_grant_id = 1'b0;
        end
        w_handshake = (r_state == S_IDLE) && (w_req_valid != 2'b00) && !rst;
        r0_ready    = w_handshake && !w_grant_id;
        r1_ready    = w_handshake && w_grant_id;
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  w_next_state = w_handshake ? S_EXEC : S_IDLE;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  w_next_state = rsp_ready ? S_IDLE : S_RESP;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Operand capture: requesters may change inputs right after the handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_op_ctrl <= ALU_AND;
            r_op_id   <= 1'b0;
        end else if (w_handshake) begin
            r_op_a    <= w_grant_id ? r1_a : r0_a;
            r_op_b    <= w_grant_id ? r1_b : r0_b;
            r_op_ctrl <= w_grant_id ? r1_control : r0_control;
            r_op_id   <= w_grant_id;
        end else begin
            r_op_a    <= r_op_a;
            r_op_b    <= r_op_b;
            r_op_ctrl <= r_op_ctrl;
            r_op_id   <= r_op_id;
        end
    end

    alu #(.N(N)) u_alu (
        .i_a        (r_op_a),
        .i_b        (r_op_b),
        .i_control  (r_op_ctrl),
        .o_result   (w_alu_result),
        .o_overflow (w_alu_overflow),
        .o_zero     (w_alu_zero),
        .o_equal    (w_alu_equal)
    );

    // Response registers and round-robin pointer; prio flips only once a
    // response is consumed so a stalled consumer cannot skew fairness
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= '0;
            rsp_overflow <= 1'b0;
            rsp_zero     <= 1'b0;
            rsp_equal    <= 1'b0;
            r_prio       <= 1'b0;
        end else if (r_state == S_EXEC) begin
            rsp_valid    <= 1'b1;
            rsp_id       <= r_op_id;
            rsp_result   <= w_alu_result;
            rsp_overflow <= w_alu_overflow;
            rsp_zero     <= w_alu_zero;
            rsp_equal    <= w_alu_equal;
        end else if ((r_state == S_RESP) && rsp_ready) begin
            rsp_valid    <= 1'b0;
            r_prio       <= ~rsp_id;
        end else begin
            rsp_valid    <= rsp_valid;
            r_prio       <= r_prio;
        end
    end

endmodule
